// File: rtl/stage3_pkg.sv
// Shared encodings for the stage-3 RV32M execute unit: funct3 selectors,
// FSM states and the writeback-select code used for M-op results.
package stage3_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] RD_SEL_EM = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/stage3_muldiv_iter.sv
// Radix-2 iterative multiply/divide core: magnitude datapath, 32-step
// sequencer, early-out for divide special cases and final sign fix-up.
module muldiv_iter
  import stage3_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  state_t            state;
  logic [CW-1:0]     count;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   hi, lo, b_q;
  logic              sa, sb;

  logic              a_signed, b_signed, s_a, s_b, div_zero, ovf, fast;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] fast_prod;

  assign a_signed = (op == F3_MULH) | (op == F3_MULHSU) | (op == F3_DIV) | (op == F3_REM);
  assign b_signed = (op == F3_MULH) | (op == F3_DIV) | (op == F3_REM);
  assign s_a      = a_signed & a[XLEN-1];
  assign s_b      = b_signed & b[XLEN-1];
  assign mag_a    = s_a ? -a : a;
  assign mag_b    = s_b ? -b : b;
  assign div_zero = is_div(op) & (b == '0);
  assign ovf      = ((op == F3_DIV) | (op == F3_REM)) & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
  assign fast     = FAST_MUL & ~is_div(op);
  assign fast_prod = (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);

  // hi:lo is the 64-bit product for multiplies, remainder:quotient for divides
  logic [XLEN:0]   sum, shifted, diff;
  logic [XLEN-1:0] hi_n, lo_n;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, b_q};
    hi_n    = sum[XLEN:1];
    lo_n    = {sum[0], lo[XLEN-1:1]};
    if (is_div(op_q)) begin
      if (!diff[XLEN]) begin
        hi_n = diff[XLEN-1:0];
        lo_n = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_n = shifted[XLEN-1:0];
        lo_n = {lo[XLEN-2:0], 1'b0};
      end
    end
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;

  always_comb begin
    prod_s = (sa ^ sb) ? -{hi, lo} : {hi, lo};
    quo_s  = (sa ^ sb) ? -lo : lo;
    rem_s  = sa ? -hi : hi;
    case (op_q)
      F3_MUL:                        result = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  result = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               result = quo_s;
      default:                       result = rem_s;
    endcase
  end

  assign busy = (state == ST_BUSY);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      op_q  <= '0;
      hi    <= '0;
      lo    <= '0;
      b_q   <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q <= op;
            b_q  <= mag_b;
            sa   <= s_a;
            sb   <= s_b;
            // Special cases preload final magnitudes with signs cleared
            if (div_zero) begin
              hi    <= a;
              lo    <= '1;
              sa    <= 1'b0;
              sb    <= 1'b0;
              state <= ST_DONE;
            end else if (ovf) begin
              hi    <= '0;
              lo    <= {1'b1, {(XLEN-1){1'b0}}};
              sa    <= 1'b0;
              sb    <= 1'b0;
              state <= ST_DONE;
            end else if (fast) begin
              {hi, lo} <= fast_prod;
              state    <= ST_DONE;
            end else begin
              hi    <= '0;
              lo    <= mag_a;
              count <= CW'(XLEN-1);
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          hi    <= hi_n;
          lo    <= lo_n;
          count <= count - 1'b1;
          if (count == '0) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/stage3_muldiv.sv
// Stage-3 execute unit: passes ALU results through the EX/MEM register and
// stalls upstream while an RV32M op runs on the iterative core.
module stage3_muldiv
  import stage3_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            m_op,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rv1,
  input  logic [XLEN-1:0] rv2,
  input  logic [XLEN-1:0] alu_result,
  input  logic [4:0]      rd_in,
  input  logic [1:0]      rd_sel_in,
  output logic            stall,
  output logic [XLEN-1:0] rwdata_em,
  output logic [1:0]      rd_sel,
  output logic [4:0]      rd_em,
  output logic            wb_en
);

  logic            busy, done, idle, start;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] md_result;

  // DONE is excluded so the still-present M-op cannot retrigger the core
  assign idle  = ~busy & ~done;
  assign start = idle & in_valid & m_op;
  assign stall = start | busy;

  muldiv_iter #(
    .XLEN     (XLEN),
    .FAST_MUL (FAST_MUL)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (funct3),
    .a      (rv1),
    .b      (rv2),
    .busy   (busy),
    .done   (done),
    .result (md_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q      <= '0;
      rwdata_em <= '0;
      rd_sel    <= '0;
      rd_em     <= '0;
      wb_en     <= 1'b0;
    end else begin
      if (start) rd_q <= rd_in;
      if (!stall && done) begin
        rwdata_em <= md_result;
        rd_sel    <= RD_SEL_EM;
        rd_em     <= rd_q;
        wb_en     <= 1'b1;
      end else if (!stall && in_valid && !m_op) begin
        rwdata_em <= alu_result;
        rd_sel    <= rd_sel_in;
        rd_em     <= rd_in;
        wb_en     <= 1'b1;
      end else begin
        rwdata_em <= '0;
        rd_sel    <= '0;
        rd_em     <= '0;
        wb_en     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stage3_muldiv.sv
// Directed bench for stage3_muldiv: vector table of M-ops plus hand-written
// sequences for back-to-back non-M issue and mid-operation reset.
module tb_stage3_muldiv;
  import stage3_pkg::*;

  logic        clk, reset, in_valid, m_op;
  logic [2:0]  funct3;
  logic [31:0] rv1, rv2, alu_result;
  logic [4:0]  rd_in;
  logic [1:0]  rd_sel_in;
  logic        stall, wb_en;
  logic [31:0] rwdata_em;
  logic [1:0]  rd_sel;
  logic [4:0]  rd_em;

  int tests = 0;
  int fails = 0;

  stage3_muldiv #(.XLEN(32), .FAST_MUL(1'b0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .m_op(m_op), .funct3(funct3),
    .rv1(rv1), .rv2(rv2), .alu_result(alu_result), .rd_in(rd_in),
    .rd_sel_in(rd_sel_in), .stall(stall), .rwdata_em(rwdata_em),
    .rd_sel(rd_sel), .rd_em(rd_em), .wb_en(wb_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stalls;
  } vec_t;

  vec_t vecs[0:15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue at a negedge; returns at the negedge after the result is registered
  task automatic run_mop(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input int exp_stalls,
                         input logic [31:0] exp);
    int n;
    in_valid   = 1'b1;
    m_op       = 1'b1;
    funct3     = f3;
    rv1        = a;
    rv2        = b;
    rd_in      = rd;
    alu_result = 32'hDEADBEEF;
    rd_sel_in  = 2'b11;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, " stall_cycles"}, n, exp_stalls);
    check({name, " wb_en_while_stalled"}, {31'b0, wb_en}, 32'd0);
    @(negedge clk);
    check({name, " result"}, rwdata_em, exp);
    check({name, " wb_en"}, {31'b0, wb_en}, 32'd1);
    check({name, " rd_sel"}, {30'b0, rd_sel}, 32'd0);
    check({name, " rd_em"}, {27'b0, rd_em}, {27'b0, rd});
    in_valid = 1'b0;
    m_op     = 1'b0;
  endtask

  initial begin
    int wb_seen;
    vecs[0]  = '{"MUL",       F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{"MUL_negneg", F3_MUL,   32'hFFFFFFFE, 32'hFFFFFFFD, 32'd6,        33};
    vecs[2]  = '{"MULH",      F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[3]  = '{"MULHU",     F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[4]  = '{"MULHSU",    F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[5]  = '{"DIV",       F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[6]  = '{"REM",       F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[7]  = '{"DIVU",      F3_DIVU,   32'd100,      32'd7,        32'd14,       33};
    vecs[8]  = '{"REMU",      F3_REMU,   32'd100,      32'd7,        32'd2,        33};
    vecs[9]  = '{"DIV_by0",   F3_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[10] = '{"REM_by0",   F3_REM,    32'd5,        32'd0,        32'd5,        1};
    vecs[11] = '{"DIVU_by0",  F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[12] = '{"REMU_by0",  F3_REMU,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 1};
    vecs[13] = '{"DIV_ovf",   F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[14] = '{"REM_ovf",   F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[15] = '{"DIV_negpos", F3_DIV,   32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33};

    reset = 1'b1; in_valid = 1'b0; m_op = 1'b0; funct3 = '0;
    rv1 = '0; rv2 = '0; alu_result = '0; rd_in = '0; rd_sel_in = '0;
    repeat (2) @(negedge clk);
    check("reset rwdata_em", rwdata_em, 32'd0);
    check("reset wb_en", {31'b0, wb_en}, 32'd0);
    check("reset rd_em", {27'b0, rd_em}, 32'd0);
    check("reset rd_sel", {30'b0, rd_sel}, 32'd0);
    check("reset stall", {31'b0, stall}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++)
      run_mop(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].stalls, vecs[i].exp);

    // Non-M op issued right after the M-op's DONE cycle
    in_valid = 1'b1; m_op = 1'b0; alu_result = 32'h1234; rd_sel_in = 2'b01; rd_in = 5'd5;
    #1;
    check("nonm stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    check("nonm rwdata_em", rwdata_em, 32'h1234);
    check("nonm rd_sel", {30'b0, rd_sel}, 32'd1);
    check("nonm rd_em", {27'b0, rd_em}, 32'd5);
    check("nonm wb_en", {31'b0, wb_en}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check("bubble wb_en", {31'b0, wb_en}, 32'd0);
    check("bubble rd_em", {27'b0, rd_em}, 32'd0);

    // Reset in the tenth BUSY cycle abandons the op
    in_valid = 1'b1; m_op = 1'b1; funct3 = F3_MUL; rv1 = 32'd9; rv2 = 32'd9; rd_in = 5'd7;
    repeat (10) @(negedge clk);
    check("busy10 stall", {31'b0, stall}, 32'd1);
    reset = 1'b1; in_valid = 1'b0; m_op = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("post_reset stall", {31'b0, stall}, 32'd0);
    check("post_reset wb_en", {31'b0, wb_en}, 32'd0);
    check("post_reset rwdata_em", rwdata_em, 32'd0);
    wb_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (wb_en === 1'b1 || stall === 1'b1) wb_seen++;
    end
    check("abandoned_op activity", wb_seen, 32'd0);
    run_mop("MUL_after_reset", F3_MUL, 32'd3, 32'd4, 5'd9, 33, 32'd12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
